// File: rtl/bram_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store) in front of a single-port
// block RAM: one grant per cycle, data priority with a fetch starvation guard.
module bram_arbiter #(
   parameter int ADDR_W     = 18,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_req,
   input  logic [31:0]       f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [31:0]       f_rdata,
   output logic              f_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   // Handshake: a requester holds req (and its payload) until it sees gnt in the
   // same cycle; the transfer happens on that edge and exactly one rvalid pulse
   // follows in the next cycle. req still high after gnt is a new request.

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } owner_t;

   logic [CNT_W-1:0] starve_cnt;
   logic             f_legal;
   logic             d_legal;
   owner_t           rsp_owner;
   owner_t           rsp_owner_next;
   logic             rsp_err;
   logic             rsp_err_next;
   logic             rsp_write;
   logic             rsp_write_next;

   function automatic logic addr_legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && ((a >> (ADDR_W + 2)) == 32'd0);
   endfunction

   assign f_legal = addr_legal(f_addr);
   assign d_legal = addr_legal(d_addr);

   // Grant logic; the whole arbiter is held quiet while reset is high.
   always_comb begin
      d_gnt = 1'b0;
      f_gnt = 1'b0;
      if (!reset) begin
         d_gnt = d_req && !(f_req && (starve_cnt == STARVE_LIM));
         f_gnt = f_req && !d_gnt;
      end
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (d_gnt && d_legal) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr[ADDR_W+1:2];
         mem_wdata = d_wdata;
      end else if (f_gnt && f_legal) begin
         mem_en   = 1'b1;
         mem_addr = f_addr[ADDR_W+1:2];
      end
   end

   // Counts consecutive cycles fetch lost to data while requesting.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!f_req || f_gnt) begin
         starve_cnt <= '0;
      end else if (d_gnt && (starve_cnt != STARVE_LIM)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_owner <= OWN_NONE;
         rsp_err   <= 1'b0;
         rsp_write <= 1'b0;
      end else begin
         rsp_owner <= rsp_owner_next;
         rsp_err   <= rsp_err_next;
         rsp_write <= rsp_write_next;
      end
   end

   always_comb begin
      rsp_owner_next = OWN_NONE;
      rsp_err_next   = 1'b0;
      rsp_write_next = 1'b0;
      if (d_gnt) begin
         rsp_owner_next = OWN_DATA;
         rsp_err_next   = !d_legal;
         rsp_write_next = d_we;
      end else if (f_gnt) begin
         rsp_owner_next = OWN_FETCH;
         rsp_err_next   = !f_legal;
      end
   end

   // Masking with reset drops a response that was scheduled just before reset.
   always_comb begin
      f_rvalid = !reset && (rsp_owner == OWN_FETCH);
      d_rvalid = !reset && (rsp_owner == OWN_DATA);
      f_err    = f_rvalid && rsp_err;
      d_err    = d_rvalid && rsp_err;
      f_rdata  = (f_rvalid && !rsp_err) ? mem_rdata : 32'd0;
      d_rdata  = (d_rvalid && !rsp_err && !rsp_write) ? mem_rdata : 32'd0;
   end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed scenarios followed by random traffic, all
// checked against a queue-based reference model and a behavioural RAM.
module tb_bram_arbiter;

   localparam int ADDR_W     = 18;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              f_req;
   logic [31:0]       f_addr;
   logic              f_gnt;
   logic              f_rvalid;
   logic [31:0]       f_rdata;
   logic              f_err;
   logic              d_req;
   logic              d_we;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic              d_err;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   bram_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .f_err(f_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // clock block
   always #5 clk = ~clk;

   // RAM device contents and reference-model view of memory
   logic [31:0] bram[0:63];
   logic [31:0] ref_mem[0:63];

   // scoreboard: expected responses as {err, rdata}
   logic [32:0] f_exp_q[$];
   logic [32:0] d_exp_q[$];
   int          denied;
   logic        last_fg;
   logic        last_dg;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a < 32'h0010_0000);
   endfunction

   function automatic logic [31:0] rand_addr();
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 63)) * 4;
      if (r == 0) a = a + 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'h1 << $urandom_range(20, 31);
      return a;
   endfunction

   // One clock cycle: check DUT against the model, run the RAM, advance.
   task automatic cycle();
      logic        ef, ed, fl, dl, exp_en, ram_en, ram_we;
      logic [32:0] r;
      logic [5:0]  ram_idx;
      logic [31:0] ram_wd;
      #1;
      fl = legal(f_addr);
      dl = legal(d_addr);
      ed = !reset && d_req && !(f_req && denied == STARVE_MAX);
      ef = !reset && f_req && !ed;
      check("f_gnt", f_gnt, ef);
      check("d_gnt", d_gnt, ed);
      exp_en = (ed && dl) || (ef && fl);
      check("mem_en", mem_en, exp_en);
      check("mem_we", mem_we, ed && dl && d_we);
      if (exp_en) check("mem_addr", mem_addr, ed ? d_addr[19:2] : f_addr[19:2]);
      if (ed && dl && d_we) check("mem_wdata", mem_wdata, d_wdata);
      if (!ed && !ef) begin
         check("idle_addr", mem_addr, 0);
         check("idle_wdata", mem_wdata, 0);
      end
      if (reset) begin
         f_exp_q.delete();
         d_exp_q.delete();
      end
      check("f_rvalid", f_rvalid, f_exp_q.size() != 0);
      if (f_exp_q.size() != 0) begin
         r = f_exp_q.pop_front();
         check("f_err", f_err, r[32]);
         check("f_rdata", f_rdata, r[31:0]);
      end else check("f_rdata_idle", f_rdata, 0);
      check("d_rvalid", d_rvalid, d_exp_q.size() != 0);
      if (d_exp_q.size() != 0) begin
         r = d_exp_q.pop_front();
         check("d_err", d_err, r[32]);
         check("d_rdata", d_rdata, r[31:0]);
      end else check("d_rdata_idle", d_rdata, 0);
      if (ef) f_exp_q.push_back(fl ? {1'b0, ref_mem[f_addr[7:2]]} : {1'b1, 32'd0});
      if (ed) begin
         if (!dl) d_exp_q.push_back({1'b1, 32'd0});
         else if (d_we) d_exp_q.push_back({1'b0, 32'd0});
         else d_exp_q.push_back({1'b0, ref_mem[d_addr[7:2]]});
         if (dl && d_we) ref_mem[d_addr[7:2]] = d_wdata;
      end
      if (reset || !f_req || ef) denied = 0;
      else if (denied < STARVE_MAX) denied++;
      last_fg = ef;
      last_dg = ed;
      ram_en  = mem_en;
      ram_we  = mem_we;
      ram_idx = mem_addr[5:0];
      ram_wd  = mem_wdata;
      @(posedge clk);
      if (ram_en) begin
         if (ram_we) bram[ram_idx] = ram_wd;
         else mem_rdata = bram[ram_idx];
      end
      #1;
   endtask

   task automatic drive_random();
      reset = ($urandom_range(0, 63) == 0);
      if (last_fg || !f_req) begin
         f_req = ($urandom_range(0, 3) != 0);
         f_addr = rand_addr();
      end
      if (last_dg || !d_req) begin
         d_req = ($urandom_range(0, 2) != 0);
         d_we = $urandom_range(0, 1);
         d_addr = rand_addr();
         d_wdata = $urandom;
      end
   endtask

   initial begin
      int first_f;
      int second_f;
      for (int i = 0; i < 64; i++) begin
         bram[i] = $urandom;
         ref_mem[i] = bram[i];
      end
      bram[4] = 32'hDEAD_BEEF;
      ref_mem[4] = 32'hDEAD_BEEF;
      mem_rdata = 32'd0;
      denied = 0;
      last_fg = 1'b0;
      last_dg = 1'b0;
      // reset held with both requesting, then data wins on release
      reset = 1'b1;
      f_req = 1'b1; f_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wdata = 32'd0;
      cycle();
      cycle();
      reset = 1'b0;
      cycle();
      check("release_dgnt", last_dg, 1'b1);
      // single fetch of word 4
      d_req = 1'b0;
      cycle();
      f_req = 1'b0;
      cycle();
      // write then back-to-back read of the same address
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
      cycle();
      d_we = 1'b0;
      cycle();
      d_req = 1'b0;
      cycle();
      check("wr_rd_mem", ref_mem[8], 32'h1234_5678);
      cycle();
      // starvation guard with both held high
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
      f_req = 1'b1; f_addr = 32'h0;
      first_f = -1;
      second_f = -1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (last_fg && first_f < 0) first_f = i;
         else if (last_fg && second_f < 0) second_f = i;
      end
      check("starve_first", first_f, STARVE_MAX);
      check("starve_second", second_f, 2 * STARVE_MAX + 1);
      // misaligned data, out-of-range fetch
      f_req = 1'b0;
      d_addr = 32'h3;
      cycle();
      d_req = 1'b0;
      cycle();
      f_req = 1'b1; f_addr = 32'h0010_0000;
      cycle();
      f_req = 1'b0;
      cycle();
      // reset right after a fetch grant drops its response
      f_req = 1'b1; f_addr = 32'h10;
      cycle();
      f_req = 1'b0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      cycle();
      cycle();
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         drive_random();
         cycle();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Shares the single-port block RAM between the CPU's instruction-fetch path and its load/store path. Each cycle it grants at most one requester and drives the RAM command port. One cycle later it returns read data or a write acknowledge to the granted requester. Data accesses have priority, with a starvation guard so fetch always makes progress. Misaligned and out-of-range addresses are rejected without touching the RAM.

## Interface
Parameters:
- ADDR_W, 18: RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
- STARVE_MAX, 4: consecutive cycles fetch may be denied while requesting before it is forced to win.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request; held until f_gnt.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch granted this cycle (combinational).
- f_rvalid  out  1  fetch response valid (registered).
- f_rdata  out  32  fetch read data; 0 when f_rvalid=0 or on error.
- f_err  out  1  fetch response is an error; meaningful only with f_rvalid.
- d_req  in  1  data request; held, with d_we/d_addr/d_wdata stable, until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data granted this cycle (combinational).
- d_rvalid  out  1  data response valid (registered); pulses for reads and writes.
- d_rdata  out  32  data read data; 0 for writes, errors, or when idle.
- d_err  out  1  data response is an error.
- mem_en  out  1  RAM access enable (combinational).
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en.

## Operation
- Address check, per requester: the address is legal iff addr[1:0]==0 and addr[31:ADDR_W+2]==0. Word address is addr[ADDR_W+1:2].
- Arbitration, evaluated combinationally each cycle while reset=0:
  - Only one requester active: that requester wins.
  - Both active: data wins, unless starve_cnt==STARVE_MAX, in which case fetch wins.
- Starvation counter starve_cnt:
  - Increments, saturating at STARVE_MAX, on each cycle where f_req=1 and d_gnt=1.
  - Clears on f_gnt, and on any cycle with f_req=0.
- Granted and legal:
  - mem_en=1, mem_addr = word address.
  - For data: mem_we=d_we, mem_wdata=d_wdata. For fetch: mem_we=0.
- Granted and illegal:
  - Grant still asserted; mem_en=0.
  - The error response is scheduled for the next cycle.
- Not granted: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Response register: owner (none/fetch/data), is_err, and is_write are captured at the grant edge.
  - Next cycle, the owner's rvalid=1.
  - rdata = mem_rdata for a legal read, else 0.
  - err = is_err.
  - The other requester's rvalid=0.
- Grants are fully pipelined: a new grant may issue in the same cycle a response is presented. Back-to-back grants to the same or alternating requesters are allowed, giving throughput of 1 access/cycle.

## Timing
- Reset asserted (sampled high at an edge): f_rvalid, d_rvalid, f_err, d_err and starve_cnt clear to 0, and the response owner clears to none. f_rdata and d_rdata read 0.
- While reset=1, f_gnt=d_gnt=mem_en=mem_we=0 combinationally.
- Reset mid-operation: a response scheduled for the cycle after reset is dropped; no rvalid is produced for it.
- Latency: request granted in cycle N gives response in cycle N+1, for every case (read, write, error).
- Write to address A in cycle N followed by a read of A granted in N+1 returns the new data in N+2; RAM write-then-read ordering is per grant order.
- A requester may drop req only after seeing gnt. req=1 with a stable payload after gnt is treated as a new request.
- Simultaneous f_req and d_req with starve_cnt<STARVE_MAX: d_gnt=1, f_gnt=0.
- Worst-case fetch wait under continuous data traffic: STARVE_MAX cycles denied, granted on cycle STARVE_MAX+1.

## Test plan
- Reset: drive reset=1 for 2 cycles with f_req=d_req=1 → both gnts, mem_en and both rvalids are 0 throughout. One cycle after release, d_gnt=1.
- Single fetch: f_addr=0x10, RAM word 4 = 0xDEADBEEF → mem_addr=4 in cycle N; f_rvalid=1 and f_rdata=0xDEADBEEF in N+1; f_err=0.
- Write then read: d_we=1, d_addr=0x20, d_wdata=0x12345678, then read 0x20 back-to-back → d_rvalid in both following cycles, with d_rdata=0 then 0x12345678.
- Starvation: d_req and f_req held high continuously with STARVE_MAX=4 → four data grants, then f_gnt on the 5th cycle, then data wins again for the next 4 cycles.
- Errors: d_addr=0x3 → d_gnt=1, mem_en=0, next cycle d_rvalid=1, d_err=1, d_rdata=0. f_addr=0x0010_0000 with ADDR_W=18 (out of range) → f_err=1.
- Reset mid-flight: grant a fetch read in cycle N, assert reset at the N+1 edge → f_rvalid stays 0 and no stale data appears after release.
